// File: rtl/ysyx_040750_pkg.sv
// ysyx_040750_pkg -- shared definitions for the instruction fetch unit.
//   ifu_state_e       : fetch FSM state encoding
//   RESET_PC_DEFAULT  : first fetch address after reset
//   word_align()      : clears the two byte-offset bits of an address
//   seq_pc()          : sequential next PC (pc + 4, wraps modulo 2^32)
package ysyx_040750_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RSP    = 3'd2,
    S_OUT    = 3'd3,
    S_WAITPC = 3'd4
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_040750_if_id_reg.sv
// ysyx_040750_if_id_reg -- IF/ID pipeline register.
//   I_clk, I_rst      : clock, synchronous active-high reset
//   load_i            : capture pc/snpc/inst and raise valid
//   clear_i           : drop valid (payload is left as is)
//   pc_i/snpc_i/inst_i: payload to capture
//   valid_o/pc_o/snpc_o/inst_o : registered IF/ID contents
module ysyx_040750_if_id_reg (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] snpc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] snpc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] snpc_q;
  logic [31:0] inst_q;

  // IF/ID payload and valid flag; load has priority over clear.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      snpc_q  <= 32'd0;
      inst_q  <= 32'd0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      snpc_q  <= snpc_i;
      inst_q  <= inst_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign snpc_o  = snpc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/ysyx_040750_ifu.sv
// ysyx_040750_ifu -- instruction fetch unit.
//   Fetches one instruction per PC: issues a request on the imem request
//   channel, waits for the response, presents it on IF/ID, then waits for
//   the next PC from the next-PC generator.
//   I_clk, I_rst                      : clock, synchronous active-high reset
//   I_dnpc, I_dnpc_valid, O_dnpc_ready: next-PC handshake
//   I_flush                           : discard the fetch in flight / held
//   O_imem_req_valid, O_imem_addr, I_imem_req_ready : request channel
//   I_imem_rsp_valid, I_imem_rdata, O_imem_rsp_ready: response channel
//   O_IF_ID_*, I_IF_ID_ready          : IF/ID output handshake
module ysyx_040750_ifu
  import ysyx_040750_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_dnpc,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  input  logic        I_flush,
  output logic        O_imem_req_valid,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_req_ready,
  input  logic        I_imem_rsp_valid,
  input  logic [31:0] I_imem_rdata,
  output logic        O_imem_rsp_ready,
  output logic        O_IF_ID_valid,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  input  logic        I_IF_ID_ready
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;   // a flushed request is still outstanding

  logic        load_s;
  logic        clear_s;
  logic        dnpc_ready_s;
  logic        req_valid_s;
  logic        rsp_ready_s;
  logic        ifid_valid_s;
  logic [31:0] ifid_pc_s;
  logic [31:0] ifid_snpc_s;
  logic [31:0] ifid_inst_s;

  // FSM state, fetch PC and drop flag.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    dnpc_ready_s = 1'b0;
    req_valid_s  = 1'b0;
    rsp_ready_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // The request stays up through a flush; its response is dropped later.
        req_valid_s = 1'b1;
        if (I_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (I_imem_req_ready) begin
          state_d = S_RSP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RSP: begin
        rsp_ready_s = 1'b1;
        if (I_imem_rsp_valid) begin
          // A response is either stale (earlier flush) or killed by a
          // same-cycle flush; both cases discard it and leave drop clear.
          if (drop_q || I_flush) begin
            drop_d  = 1'b0;
            state_d = S_WAITPC;
          end else begin
            load_s  = 1'b1;
            state_d = S_OUT;
          end
        end else if (I_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      S_OUT: begin
        // Flush wins over a same-cycle IF/ID handshake.
        if (I_flush || I_IF_ID_ready) begin
          clear_s = 1'b1;
          state_d = S_WAITPC;
        end else begin
          state_d = S_OUT;
        end
      end
      S_WAITPC: begin
        dnpc_ready_s = ~I_flush;
        if (I_dnpc_valid && !I_flush) begin
          pc_d    = I_dnpc;
          state_d = S_REQ;
        end else begin
          state_d = S_WAITPC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  ysyx_040750_if_id_reg u_if_id_reg (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .load_i  (load_s),
    .clear_i (clear_s),
    .pc_i    (pc_q),
    .snpc_i  (seq_pc(pc_q)),
    .inst_i  (I_imem_rdata),
    .valid_o (ifid_valid_s),
    .pc_o    (ifid_pc_s),
    .snpc_o  (ifid_snpc_s),
    .inst_o  (ifid_inst_s)
  );

  // Every output is forced low while reset is held, even before the first
  // reset edge has landed in the registers.
  assign O_dnpc_ready     = dnpc_ready_s & ~I_rst;
  assign O_imem_req_valid = req_valid_s & ~I_rst;
  assign O_imem_addr      = (req_valid_s && !I_rst) ? word_align(pc_q) : 32'd0;
  assign O_imem_rsp_ready = rsp_ready_s & ~I_rst;
  assign O_IF_ID_valid    = ifid_valid_s & ~I_rst;
  assign O_IF_ID_pc       = I_rst ? 32'd0 : ifid_pc_s;
  assign O_IF_ID_snpc     = I_rst ? 32'd0 : ifid_snpc_s;
  assign O_IF_ID_inst     = I_rst ? 32'd0 : ifid_inst_s;

endmodule

// File: tb/tb_ysyx_040750_ifu.sv
// tb_ysyx_040750_ifu -- self-checking bench for ysyx_040750_ifu.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A transaction-level model tracks which PC is being
// fetched and whether it has been flushed, and checks every request and
// every IF/ID delivery against it.
module tb_ysyx_040750_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [31:0] I_dnpc;
  logic        I_dnpc_valid;
  logic        O_dnpc_ready;
  logic        I_flush;
  logic        O_imem_req_valid;
  logic [31:0] O_imem_addr;
  logic        I_imem_req_ready;
  logic        I_imem_rsp_valid;
  logic [31:0] I_imem_rdata;
  logic        O_imem_rsp_ready;
  logic        O_IF_ID_valid;
  logic [31:0] O_IF_ID_pc;
  logic [31:0] O_IF_ID_snpc;
  logic [31:0] O_IF_ID_inst;
  logic        I_IF_ID_ready;

  always #5 I_clk = ~I_clk;

  ysyx_040750_ifu dut (
    .I_clk            (I_clk),
    .I_rst            (I_rst),
    .I_dnpc           (I_dnpc),
    .I_dnpc_valid     (I_dnpc_valid),
    .O_dnpc_ready     (O_dnpc_ready),
    .I_flush          (I_flush),
    .O_imem_req_valid (O_imem_req_valid),
    .O_imem_addr      (O_imem_addr),
    .I_imem_req_ready (I_imem_req_ready),
    .I_imem_rsp_valid (I_imem_rsp_valid),
    .I_imem_rdata     (I_imem_rdata),
    .O_imem_rsp_ready (O_imem_rsp_ready),
    .O_IF_ID_valid    (O_IF_ID_valid),
    .O_IF_ID_pc       (O_IF_ID_pc),
    .O_IF_ID_snpc     (O_IF_ID_snpc),
    .O_IF_ID_inst     (O_IF_ID_inst),
    .I_IF_ID_ready    (I_IF_ID_ready)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory contents: the reset vector holds a nop, everything else ~address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0013 : ~a;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    logic [31:0] m;
    m = 32'hFFFF_FFFC;
    return a & m;
  endfunction

  function automatic logic outs_zero();
    return !(O_dnpc_ready || O_imem_req_valid || O_imem_rsp_ready || O_IF_ID_valid) &&
           (O_imem_addr == 32'd0) && (O_IF_ID_pc == 32'd0) &&
           (O_IF_ID_snpc == 32'd0) && (O_IF_ID_inst == 32'd0);
  endfunction

  // Per-cycle stimulus requested by the test body.
  logic        t_rst, t_flush, t_dv, t_rdy;
  logic [31:0] t_dnpc;
  int          m_mode;     // 0 random req_ready, 1 always ready, 2 never ready
  logic        m_drand;    // random response delay 0..3
  int          m_delay;    // fixed response delay when m_drand is 0

  // Memory model state.
  logic        mp;
  logic [31:0] mp_addr;
  int          mp_wait;

  // Reference model state.
  logic [31:0] exp_pc;
  logic        outstanding, flushed, idle_cyc;
  int          nreq, ndeliv;
  logic        ps_req, ps_out;
  logic [31:0] ps_addr, ps_pc, ps_snpc, ps_inst;

  task automatic monitor();
    if (I_rst) begin
      check("rst_outputs_zero", {31'd0, outs_zero()}, 32'd1);
      exp_pc = RPC; outstanding = 1'b1; flushed = 1'b0; nreq = 0;
      idle_cyc = 1'b1; mp = 1'b0; ps_req = 1'b0; ps_out = 1'b0;
    end else if (idle_cyc) begin
      // One idle cycle after reset: nothing driven, flush has no effect.
      check("idle_outputs_zero", {31'd0, outs_zero()}, 32'd1);
      idle_cyc = 1'b0;
    end else begin
      if (ps_req) begin
        check("req_hold_valid", {31'd0, O_imem_req_valid}, 32'd1);
        check("req_hold_addr", O_imem_addr, ps_addr);
      end
      if (ps_out) begin
        check("out_hold_valid", {31'd0, O_IF_ID_valid}, 32'd1);
        check("out_hold_pc", O_IF_ID_pc, ps_pc);
        check("out_hold_snpc", O_IF_ID_snpc, ps_snpc);
        check("out_hold_inst", O_IF_ID_inst, ps_inst);
      end
      if (I_flush) check("flush_blocks_dnpc_ready", {31'd0, O_dnpc_ready}, 32'd0);
      if (O_dnpc_ready) begin
        check("dnpc_ready_while_busy", {31'd0, outstanding && !flushed}, 32'd0);
        outstanding = 1'b0;
        if (I_dnpc_valid) begin
          exp_pc = I_dnpc; outstanding = 1'b1; flushed = 1'b0; nreq = 0;
        end
      end
      if (O_imem_rsp_ready && I_imem_rsp_valid) mp = 1'b0;
      if (O_imem_req_valid && I_imem_req_ready) begin
        check("req_addr", O_imem_addr, align(exp_pc));
        check("one_req_per_fetch", nreq, 32'd0);
        check("req_while_pending", {31'd0, mp}, 32'd0);
        nreq++;
        mp = 1'b1; mp_addr = O_imem_addr;
        mp_wait = m_drand ? int'($urandom_range(0, 3)) : m_delay;
      end else if (mp && mp_wait > 0) begin
        mp_wait--;
      end
      if (O_IF_ID_valid && I_IF_ID_ready && !I_flush) begin
        check("deliver_expected", {31'd0, outstanding && !flushed}, 32'd1);
        check("deliver_pc", O_IF_ID_pc, exp_pc);
        check("deliver_snpc", O_IF_ID_snpc, exp_pc + 32'd4);
        check("deliver_inst", O_IF_ID_inst, memf(align(exp_pc)));
        outstanding = 1'b0;
        ndeliv++;
      end
      if (I_flush && outstanding) flushed = 1'b1;
      ps_req  = O_imem_req_valid && !I_imem_req_ready;
      ps_addr = O_imem_addr;
      ps_out  = O_IF_ID_valid && !I_IF_ID_ready && !I_flush;
      ps_pc   = O_IF_ID_pc;
      ps_snpc = O_IF_ID_snpc;
      ps_inst = O_IF_ID_inst;
    end
  endtask

  // One clock cycle: apply stimulus after the edge, sample on the falling edge.
  task automatic cyc();
    @(posedge I_clk);
    #1;
    I_rst         = t_rst;
    I_flush       = t_flush;
    I_dnpc_valid  = t_dv;
    I_dnpc        = t_dnpc;
    I_IF_ID_ready = t_rdy;
    case (m_mode)
      0:       I_imem_req_ready = ($urandom_range(0, 3) != 0);
      1:       I_imem_req_ready = 1'b1;
      default: I_imem_req_ready = 1'b0;
    endcase
    I_imem_rsp_valid = mp && (mp_wait == 0);
    I_imem_rdata     = mp ? memf(mp_addr) : 32'hDEAD_BEEF;
    @(negedge I_clk);
    monitor();
  endtask

  typedef struct {
    logic [31:0] dnpc;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
  } vec_t;

  vec_t tab [6];

  initial begin
    logic        seen, got;
    logic [31:0] raddr;
    int          d0;

    tab[0] = '{32'h8000_0100, 32'h8000_0100, 32'h8000_0100, 32'h8000_0104, 32'h7FFF_FEFF};
    tab[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0003};
    tab[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0003};
    tab[3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF};
    tab[4] = '{32'h1234_567B, 32'h1234_5678, 32'h1234_567B, 32'h1234_567F, 32'hEDCB_A987};
    tab[5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h0000_0013};

    I_rst = 1'b1; I_flush = 1'b0; I_dnpc_valid = 1'b0; I_dnpc = 32'd0;
    I_IF_ID_ready = 1'b0; I_imem_req_ready = 1'b0; I_imem_rsp_valid = 1'b0;
    I_imem_rdata = 32'd0;
    t_rst = 1'b1; t_flush = 1'b0; t_dv = 1'b0; t_dnpc = 32'd0; t_rdy = 1'b0;
    m_mode = 1; m_drand = 1'b0; m_delay = 0;
    mp = 1'b0; mp_addr = 32'd0; mp_wait = 0; ndeliv = 0;
    exp_pc = RPC; outstanding = 1'b1; flushed = 1'b0; idle_cyc = 1'b1; nreq = 0;
    ps_req = 1'b0; ps_out = 1'b0;
    ps_addr = 32'd0; ps_pc = 32'd0; ps_snpc = 32'd0; ps_inst = 32'd0;

    // Reset, then the first fetch with a 0-wait memory.
    repeat (3) cyc();
    t_rst = 1'b0;
    cyc();
    check("c0_req_valid", {31'd0, O_imem_req_valid}, 32'd0);
    cyc();
    check("c1_req_valid", {31'd0, O_imem_req_valid}, 32'd1);
    check("c1_addr", O_imem_addr, 32'h8000_0000);
    cyc();
    check("c2_rsp_ready", {31'd0, O_imem_rsp_ready}, 32'd1);
    check("c2_ifid_valid", {31'd0, O_IF_ID_valid}, 32'd0);
    cyc();
    check("c3_ifid_valid", {31'd0, O_IF_ID_valid}, 32'd1);
    check("c3_pc", O_IF_ID_pc, 32'h8000_0000);
    check("c3_snpc", O_IF_ID_snpc, 32'h8000_0004);
    check("c3_inst", O_IF_ID_inst, 32'h0000_0013);

    // Consumer stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", {31'd0, O_IF_ID_valid}, 32'd1);
      check("stall_pc", O_IF_ID_pc, 32'h8000_0000);
      check("stall_dnpc_ready", {31'd0, O_dnpc_ready}, 32'd0);
      check("stall_no_req", {31'd0, O_imem_req_valid}, 32'd0);
    end
    t_rdy = 1'b1; cyc();
    t_rdy = 1'b0; cyc();
    check("after_hs_valid", {31'd0, O_IF_ID_valid}, 32'd0);
    check("after_hs_dnpc_ready", {31'd0, O_dnpc_ready}, 32'd1);

    // Flush while waiting for a slow response.
    m_delay = 3; t_dv = 1'b1; t_dnpc = 32'h8000_0040; cyc();
    check("r31_accept", {31'd0, O_dnpc_ready}, 32'd1);
    t_dv = 1'b0; cyc();
    check("r31_req_addr", O_imem_addr, 32'h8000_0040);
    t_flush = 1'b1; cyc();
    check("r31_in_rsp", {31'd0, O_imem_rsp_ready}, 32'd1);
    t_flush = 1'b0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      check("r31_no_valid", {31'd0, O_IF_ID_valid}, 32'd0);
      if (O_dnpc_ready) seen = 1'b1;
    end
    check("r31_reach_waitpc", {31'd0, seen}, 32'd1);

    // Flush and dnpc in the same cycle: dnpc is taken one cycle later.
    m_delay = 0; t_flush = 1'b1; t_dv = 1'b1; t_dnpc = 32'h8000_0100; cyc();
    check("r34_ready_gated", {31'd0, O_dnpc_ready}, 32'd0);
    t_flush = 1'b0; cyc();
    check("r34_ready_next", {31'd0, O_dnpc_ready}, 32'd1);
    t_dv = 1'b0; cyc();
    check("r34_req_valid", {31'd0, O_imem_req_valid}, 32'd1);
    check("r34_req_addr", O_imem_addr, 32'h8000_0100);
    cyc(); cyc();
    check("r34_valid", {31'd0, O_IF_ID_valid}, 32'd1);
    check("r34_pc", O_IF_ID_pc, 32'h8000_0100);
    check("r34_snpc", O_IF_ID_snpc, 32'h8000_0104);
    t_rdy = 1'b1; cyc();
    t_rdy = 1'b0; cyc();

    // Request stalled for 4 cycles with a flush pulse in the middle.
    t_dv = 1'b1; t_dnpc = 32'h8000_0200; cyc();
    check("r32_accept", {31'd0, O_dnpc_ready}, 32'd1);
    t_dv = 1'b0; m_mode = 2;
    for (int i = 0; i < 4; i++) begin
      t_flush = (i == 1);
      cyc();
      check("r32_req_valid", {31'd0, O_imem_req_valid}, 32'd1);
      check("r32_req_addr", O_imem_addr, 32'h8000_0200);
    end
    t_flush = 1'b0; m_mode = 1; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      check("r32_no_valid", {31'd0, O_IF_ID_valid}, 32'd0);
      if (O_dnpc_ready) seen = 1'b1;
    end
    check("r32_reach_waitpc", {31'd0, seen}, 32'd1);

    // Table of fetch addresses, including wrap-around and unaligned PCs.
    m_mode = 0; m_drand = 1'b1;
    for (int v = 0; v < 6; v++) begin
      t_dv = 1'b1; t_dnpc = tab[v].dnpc; cyc();
      check("tab_accept", {31'd0, O_dnpc_ready}, 32'd1);
      t_dv = 1'b0; got = 1'b0; raddr = 32'hFFFF_FFFF;
      for (int k = 0; k < 40 && !got; k++) begin
        cyc();
        if (O_imem_req_valid && I_imem_req_ready) raddr = O_imem_addr;
        if (O_IF_ID_valid) got = 1'b1;
      end
      check("tab_got_valid", {31'd0, got}, 32'd1);
      check("tab_addr", raddr, tab[v].addr);
      check("tab_pc", O_IF_ID_pc, tab[v].pc);
      check("tab_snpc", O_IF_ID_snpc, tab[v].snpc);
      check("tab_inst", O_IF_ID_inst, tab[v].inst);
      t_rdy = 1'b1; cyc();
      t_rdy = 1'b0; cyc();
    end

    // Random traffic, flushes and occasional mid-transaction resets.
    d0 = ndeliv;
    for (int c = 0; c < 3000; c++) begin
      t_rst   = ($urandom_range(0, 599) == 0);
      t_flush = ($urandom_range(0, 9) == 0);
      t_dv    = ($urandom_range(0, 3) != 0);
      t_dnpc  = $urandom;
      t_rdy   = ($urandom_range(0, 1) == 1);
      cyc();
    end
    check("rand_progress", {31'd0, ndeliv > d0 + 50}, 32'd1);

    // Drain: the unit must come back to waiting for a PC.
    t_rst = 1'b0; t_flush = 1'b0; t_dv = 1'b0; t_rdy = 1'b1; m_mode = 1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      if (O_dnpc_ready) seen = 1'b1;
    end
    check("drain_waitpc", {31'd0, seen}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
